// File: rtl/rx_fifo_32b.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_32b
// Brief    : First-word-fall-through 32-bit receive FIFO with sticky overflow.
//            Define RX_FIFO_OVF_CNT_EN to add the saturating ovf_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo_32b #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              data_in,
  input  logic                     valid_in,
  output logic [31:0]              data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
`ifdef RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF_LEVEL = CW'(AF_LEVEL);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_pop  = (r_count != '0) && ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = valid_in && ((r_count < c_DEPTH) || w_pop);
  assign w_drop = valid_in && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= c_AF_LEVEL);
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; a write landing during reset is never exposed
  // because the pointers and count are held at zero.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr_ptr] <= data_in;
  end

  assign valid_out   = (r_count != '0);
  assign data_out    = valid_out ? r_mem[r_rd_ptr] : 32'h0;
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

`ifdef RX_FIFO_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ovf_cnt <= 8'h00;
    else if (w_drop && (r_ovf_cnt != 8'hFF))
      r_ovf_cnt <= r_ovf_cnt + 8'h01;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/rx_fifo_32b.md
RX_FIFO_32B -- requirements
Module: rx_fifo_32b

Interface
REQ-001 Parameter DEPTH, default 8, number of 32-bit word entries; power of two, minimum 4.
REQ-002 Parameter AF_LEVEL, default 6, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port data_in  input  32  word from the upstream 8b-to-32b packer.
REQ-006 Port valid_in  input  1  data_in carries a word this cycle.
REQ-007 Port data_out  output  32  head-of-queue word to the transaction layer.
REQ-008 Port valid_out  output  1  data_out holds a valid word.
REQ-009 Port ready_in  input  1  consumer accepts data_out this cycle.
REQ-010 Port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port almost_full  output  1  count >= AF_LEVEL.
REQ-012 Port overflow  output  1  sticky flag: at least one word was dropped.

Function
REQ-013 The FIFO SHALL be first-word-fall-through: valid_out = (count != 0); data_out = word at read pointer; data_out = 32'h0 when empty.
REQ-014 Pop SHALL occur when valid_out && ready_in at a rising edge; ready_in while empty SHALL have no effect.
REQ-015 Push SHALL be accepted when valid_in && (count < DEPTH || pop); the word is written at the write pointer.
REQ-016 Write-to-read latency SHALL be one cycle: a word pushed into an empty FIFO at edge N SHALL appear on data_out/valid_out immediately after edge N.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-018 Simultaneous push and ready_in while empty SHALL accept the push only; count becomes 1.
REQ-019 Push while full with no pop SHALL drop data_in, leave memory, pointers and count unchanged, and set overflow to 1.
REQ-020 Push while full with simultaneous pop SHALL be accepted (no drop, overflow unchanged).
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count alone distinguishes full from empty.
REQ-022 count, almost_full and overflow SHALL be registered values updated on the same edge as the pointers.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 Word ordering SHALL be preserved exactly; no word is duplicated or reordered across pointer wrap.

Reset
REQ-025 Asserting reset SHALL immediately clear both pointers, count = 0, almost_full = 0, overflow = 0, valid_out = 0, data_out = 32'h0, independent of clock.
REQ-026 Memory contents need not be cleared; they SHALL never be visible while count = 0.
REQ-027 Reset asserted mid-stream SHALL discard all stored words; the first push after release SHALL be the first word out.
REQ-028 A push or pop coinciding with the edge on which reset is still asserted SHALL be ignored.

Configuration
REQ-029 Macro RX_FIFO_OVF_CNT_EN, when defined, SHALL add output ovf_cnt (8 bits) counting dropped words, reset to 0, saturating at 8'hFF.
REQ-030 Without RX_FIFO_OVF_CNT_EN, port ovf_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, push 32'hA1B2C3D4 with ready_in=0 -> next cycle valid_out=1, data_out=32'hA1B2C3D4, count=1.
REQ-032 Push 8 words 32'h0..32'h7 with ready_in=0 -> count=8, almost_full=1 from count=6; a 9th push 32'hDEAD -> dropped, overflow=1, (ovf_cnt=1 if enabled); drain yields 0..7 in order.
REQ-033 Full FIFO, push 32'h8 with ready_in=1 same cycle -> count stays 8, overflow stays 0, output order 1..8.
REQ-034 Continuous push and pop for 20 cycles of incrementing words -> count constant at 1, output sequence matches input with one-cycle lag across two pointer wraps.
REQ-035 Load 5 words, assert reset between edges -> outputs clear immediately; post-reset push 32'h55 -> data_out=32'h55, count=1.
REQ-036 Empty FIFO, ready_in=1 with valid_in=1 data 32'h77 -> count=1, valid_out=1, data_out=32'h77; no spurious pop.
